sfp_dom_reader: RTL

- I2C master that performs single-byte random reads from an SFP module's two-wire management interface (SFF-8472: A0h ID EEPROM at 7'h50, A2h DOM at 7'h51).
- Sits between the SFP pad-level block and the status/display logic.
- Drives the module's SDA/SCL as open-drain and returns the read byte with ACK status.
- No clock stretching; the module is assumed to be a standard-mode slave.

---
 rtl/sfp_dom_reader_if.sv | 22 ++
 rtl/sfp_dom_reader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sfp_dom_reader_if.sv
// Request/response interface of the SFP DOM reader.
// Requester (master modport): start pulse, 7-bit device address, 8-bit register offset.
// Reader    (slave modport):  busy level, done pulse, ack_err flag, rd_data byte.
interface sfp_dom_reader_if;
   logic       start;
   logic [6:0] dev_addr;
   logic [7:0] reg_addr;
   logic       busy;
   logic       done;
   logic       ack_err;
   logic [7:0] rd_data;

   modport master (
      output start, dev_addr, reg_addr,
      input  busy, done, ack_err, rd_data
   );

   modport slave (
      input  start, dev_addr, reg_addr,
      output busy, done, ack_err, rd_data
   );
endinterface

// File: rtl/sfp_dom_reader.sv
// Single-byte I2C random-read master for an SFP two-wire management interface
// (A0h ID EEPROM at 7'h50, A2h DOM at 7'h51). Open-drain pad control, no
// clock stretching.
// Ports:
//   clk_i     system clock
//   rst_i     synchronous active-high reset
//   req       request/response interface (slave modport)
//   sda_i     SDA pad input, asynchronous
//   sda_oe_o  1 = pull SDA low
//   scl_oe_o  1 = pull SCL low
module sfp_dom_reader #(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned I2C_HZ = 100_000
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   sfp_dom_reader_if.slave      req,
   input  logic                 sda_i,
   output logic                 sda_oe_o,
   output logic                 scl_oe_o
);

   // Clocks per quarter SCL period; must be at least 2 so the one-cycle
   // registered pad lag stays inside a quarter.
   localparam int unsigned QDIV = CLK_HZ / (4 * I2C_HZ);
   localparam int unsigned QW   = (QDIV > 1) ? $clog2(QDIV) : 1;

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_WR_DEV, S_ACK1, S_WR_REG, S_ACK2, S_RSTART,
      S_WR_DEVR, S_ACK3, S_RD, S_MNACK, S_STOP, S_FIN
   } state_e;

   state_e         state_q;
   logic [QW-1:0]  qcnt_q;
   logic [1:0]     phase_q;
   logic [2:0]     bit_q;
   logic [6:0]     dev_q;
   logic [7:0]     reg_q;
   logic [7:0]     shift_q;
   logic           err_q;
   logic           busy_q;
   logic           done_q;
   logic           ack_err_q;
   logic [7:0]     rd_data_q;
   logic           sda_oe_q;
   logic           scl_oe_q;
   logic           sda_s1_q;
   logic           sda_s2_q;

   logic [7:0]     tx_byte_c;
   logic           scl_oe_d;
   logic           sda_oe_d;
   state_e         slot_next_d;
   logic           qtick_c;
   logic           scl_low_c;

   assign qtick_c   = (qcnt_q == QW'(QDIV - 1));
   assign scl_low_c = (phase_q == 2'd0) || (phase_q == 2'd3);

   // Byte currently being shifted out on a write slot.
   always_comb begin
      tx_byte_c = 8'h00;
      case (state_q)
         S_WR_DEV:  tx_byte_c = {dev_q, 1'b0};
         S_WR_REG:  tx_byte_c = reg_q;
         S_WR_DEVR: tx_byte_c = {dev_q, 1'b1};
         default:   tx_byte_c = 8'h00;
      endcase
   end

   // Pad drive for the current slot/phase; registered one cycle later.
   always_comb begin
      scl_oe_d = 1'b0;
      sda_oe_d = 1'b0;
      case (state_q)
         S_START: begin
            scl_oe_d = (phase_q == 2'd3);
            sda_oe_d = (phase_q >= 2'd2);
         end
         S_RSTART: begin
            scl_oe_d = scl_low_c;
            sda_oe_d = (phase_q >= 2'd2);
         end
         S_WR_DEV, S_WR_REG, S_WR_DEVR: begin
            scl_oe_d = scl_low_c;
            sda_oe_d = ~tx_byte_c[bit_q];
         end
         S_ACK1, S_ACK2, S_ACK3, S_RD, S_MNACK: begin
            scl_oe_d = scl_low_c;
         end
         S_STOP: begin
            scl_oe_d = (phase_q == 2'd0);
            sda_oe_d = (phase_q <= 2'd1);
         end
         default: begin
            scl_oe_d = 1'b0;
            sda_oe_d = 1'b0;
         end
      endcase
   end

   // Slot sequencing; err_q already holds this slot's ACK sample by ph3.
   always_comb begin
      slot_next_d = S_IDLE;
      case (state_q)
         S_START:   slot_next_d = S_WR_DEV;
         S_WR_DEV:  slot_next_d = (bit_q == 3'd0) ? S_ACK1 : S_WR_DEV;
         S_ACK1:    slot_next_d = err_q ? S_STOP : S_WR_REG;
         S_WR_REG:  slot_next_d = (bit_q == 3'd0) ? S_ACK2 : S_WR_REG;
         S_ACK2:    slot_next_d = err_q ? S_STOP : S_RSTART;
         S_RSTART:  slot_next_d = S_WR_DEVR;
         S_WR_DEVR: slot_next_d = (bit_q == 3'd0) ? S_ACK3 : S_WR_DEVR;
         S_ACK3:    slot_next_d = err_q ? S_STOP : S_RD;
         S_RD:      slot_next_d = (bit_q == 3'd0) ? S_MNACK : S_RD;
         S_MNACK:   slot_next_d = S_STOP;
         S_STOP:    slot_next_d = S_FIN;
         default:   slot_next_d = S_IDLE;
      endcase
   end

   // Controller FSM, quarter timebase, SDA synchronizer and registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         qcnt_q    <= '0;
         phase_q   <= 2'd0;
         bit_q     <= 3'd0;
         dev_q     <= 7'h00;
         reg_q     <= 8'h00;
         shift_q   <= 8'h00;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ack_err_q <= 1'b0;
         rd_data_q <= 8'h00;
         sda_oe_q  <= 1'b0;
         scl_oe_q  <= 1'b0;
         sda_s1_q  <= 1'b1;
         sda_s2_q  <= 1'b1;
      end else begin
         sda_s1_q <= sda_i;
         sda_s2_q <= sda_s1_q;
         sda_oe_q <= sda_oe_d;
         scl_oe_q <= scl_oe_d;
         done_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // A start coinciding with the done pulse is dropped.
               if (req.start && !done_q) begin
                  dev_q   <= req.dev_addr;
                  reg_q   <= req.reg_addr;
                  busy_q  <= 1'b1;
                  err_q   <= 1'b0;
                  qcnt_q  <= '0;
                  phase_q <= 2'd0;
                  bit_q   <= 3'd7;
                  state_q <= S_START;
               end
            end
            S_FIN: begin
               done_q    <= 1'b1;
               busy_q    <= 1'b0;
               ack_err_q <= err_q;
               if (!err_q) begin
                  rd_data_q <= shift_q;
               end
               state_q <= S_IDLE;
            end
            default: begin
               if (qtick_c) begin
                  qcnt_q  <= '0;
                  phase_q <= phase_q + 2'd1;
                  if (phase_q == 2'd2) begin
                     if (state_q inside {S_ACK1, S_ACK2, S_ACK3}) begin
                        err_q <= err_q | sda_s2_q;
                     end
                     if (state_q == S_RD) begin
                        shift_q <= {shift_q[6:0], sda_s2_q};
                     end
                  end
                  if (phase_q == 2'd3) begin
                     state_q <= slot_next_d;
                     bit_q   <= (slot_next_d == state_q) ? (bit_q - 3'd1) : 3'd7;
                  end
               end else begin
                  qcnt_q <= qcnt_q + QW'(1);
               end
            end
         endcase
      end
   end

   assign req.busy    = busy_q;
   assign req.done    = done_q;
   assign req.ack_err = ack_err_q;
   assign req.rd_data = rd_data_q;
   assign sda_oe_o    = sda_oe_q;
   assign scl_oe_o    = scl_oe_q;

endmodule
